// File: rtl/saw_pkg.sv
// saw_pkg: definitions shared by the Stop-and-Wait ARQ transmitter and receiver.
//   saw_state_t   : receiver state encoding {IDLE, CHECK, DELIVER}
//   SAW_BW        : default payload width (sequence bit + user data)
//   SAW_CRC_BW    : default CRC width appended by the transmitter
//   SAW_CRC_POLY  : CRC generator polynomial (x^8 + x^2 + x + 1, implicit top bit)
//   frame_bw()    : full frame width {payload, crc}
//   seq_idx()     : index of the sequence bit inside the payload
package saw_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        DELIVER = 2'd2
    } saw_state_t;

    localparam int SAW_BW     = 40;
    localparam int SAW_CRC_BW = 8;
    localparam logic [7:0] SAW_CRC_POLY = 8'h07;

    function automatic int frame_bw(input int bw, input int crc_bw);
        return bw + crc_bw;
    endfunction

    function automatic int seq_idx(input int bw);
        return bw - 1;
    endfunction

endpackage

// File: rtl/saw_crc.sv
// saw_crc: combinational CRC remainder over a whole input word, MSB first,
// zero initial value, no reflection. Used by both ends of the SAW link; a
// frame {payload, crc} built by the transmitter yields a remainder of 0.
//   in  [IN_BW-1:0]   : word to check
//   rem [CRC_BW-1:0]  : CRC remainder of in
module saw_crc #(
    parameter int                IN_BW  = 48,
    parameter int                CRC_BW = 8,
    parameter logic [CRC_BW-1:0] POLY   = CRC_BW'(8'h07)
) (
    input  logic [IN_BW-1:0]  in,
    output logic [CRC_BW-1:0] rem
);

    logic w_fb;

    always_comb begin
        rem  = '0;
        w_fb = 1'b0;
        for (int unsigned i = 0; i < IN_BW; i++) begin
            w_fb = rem[CRC_BW-1] ^ in[IN_BW-1-i];
            rem  = {rem[CRC_BW-2:0], 1'b0};
            if (w_fb) begin
                rem = rem ^ POLY;
            end
        end
    end

endmodule

// File: rtl/saw_receiver.sv
// saw_receiver: receiving end of the Stop-and-Wait ARQ link.
// Checks CRC-protected frames {payload, crc}, delivers new payloads over a
// valid/ready handshake, ACKs consumed or duplicate frames, NACKs bad frames.
// Optional consecutive-NACK counter and sticky link_err: macro SAW_RX_ERRCNT_EN.
//   clk, rst     : clock, synchronous active-high reset
//   frame_in     : received frame {payload, crc}; frame_valid qualifies it
//   data_out     : delivered user data; data_valid / data_ready handshake
//   ack, ack_seq : one-cycle ACK pulse and the sequence bit acknowledged
//   nack         : one-cycle NACK pulse on a bad CRC
//   link_err     : sticky, set after MAX_NACK consecutive bad frames
module saw_receiver
    import saw_pkg::*;
#(
    parameter int BW       = SAW_BW,
    parameter int CRC_BW   = SAW_CRC_BW,
    parameter int MAX_NACK = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BW+CRC_BW-1:0]   frame_in,
    input  logic                   frame_valid,
    output logic [BW-2:0]          data_out,
    output logic                   data_valid,
    input  logic                   data_ready,
    output logic                   ack,
    output logic                   ack_seq,
    output logic                   nack,
    output logic                   link_err
);

    localparam int FRAME_BW = frame_bw(BW, CRC_BW);
    localparam int SEQ_IDX  = seq_idx(BW);

    if (MAX_NACK < 1) begin : g_cfg_check
        $error("saw_receiver: MAX_NACK must be at least 1");
    end

    saw_state_t           r_state;
    logic [FRAME_BW-1:0]  r_frame_d;
    logic                 r_exp_seq;
    logic [BW-2:0]        r_data_out;
    logic                 r_data_valid;
    logic                 r_ack;
    logic                 r_ack_seq;
    logic                 r_nack;
    logic [CRC_BW-1:0]    w_rem;
    logic                 w_seq;

`ifdef SAW_RX_ERRCNT_EN
    localparam int                CNT_W      = $clog2(MAX_NACK + 1);
    localparam logic [CNT_W-1:0]  NACK_LIMIT = CNT_W'(MAX_NACK);

    logic [CNT_W-1:0]  r_nack_cnt;
    logic [CNT_W-1:0]  w_nack_cnt_nxt;
    logic              r_link_err;

    assign w_nack_cnt_nxt = (r_nack_cnt == NACK_LIMIT) ? r_nack_cnt : r_nack_cnt + 1'b1;
    assign link_err       = r_link_err;
`else
    assign link_err = 1'b0;
`endif

    saw_crc #(
        .IN_BW  (FRAME_BW),
        .CRC_BW (CRC_BW),
        .POLY   (CRC_BW'(SAW_CRC_POLY))
    ) u_crc (
        .in  (r_frame_d),
        .rem (w_rem)
    );

    assign w_seq = r_frame_d[CRC_BW + SEQ_IDX];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_frame_d    <= '0;
            r_exp_seq    <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_ack        <= 1'b0;
            r_ack_seq    <= 1'b0;
            r_nack       <= 1'b0;
`ifdef SAW_RX_ERRCNT_EN
            r_nack_cnt   <= '0;
            r_link_err   <= 1'b0;
`endif
        end else begin
            r_ack  <= 1'b0;
            r_nack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (frame_valid) begin
                        r_frame_d <= frame_in;
                        r_state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_rem != '0) begin
                        r_nack  <= 1'b1;
                        r_state <= IDLE;
`ifdef SAW_RX_ERRCNT_EN
                        r_nack_cnt <= w_nack_cnt_nxt;
                        if (w_nack_cnt_nxt == NACK_LIMIT) begin
                            r_link_err <= 1'b1;
                        end
`endif
                    end else if (w_seq == r_exp_seq) begin
                        r_data_out   <= r_frame_d[CRC_BW+BW-2:CRC_BW];
                        r_data_valid <= 1'b1;
                        r_state      <= DELIVER;
`ifdef SAW_RX_ERRCNT_EN
                        r_nack_cnt   <= '0;
`endif
                    end else begin
                        // Duplicate of an already delivered frame: re-ACK it so
                        // the transmitter can advance, drop the payload.
                        r_ack     <= 1'b1;
                        r_ack_seq <= w_seq;
                        r_state   <= IDLE;
`ifdef SAW_RX_ERRCNT_EN
                        r_nack_cnt <= '0;
`endif
                    end
                end
                DELIVER: begin
                    // ACK is withheld until the sink consumes the payload.
                    if (r_data_valid && data_ready) begin
                        r_data_valid <= 1'b0;
                        r_ack        <= 1'b1;
                        r_ack_seq    <= w_seq;
                        r_exp_seq    <= ~r_exp_seq;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign ack        = r_ack;
    assign ack_seq    = r_ack_seq;
    assign nack       = r_nack;

endmodule

// File: tb/tb_saw_receiver.sv
// tb_saw_receiver: randomized self-checking bench for saw_receiver against a
// transaction-level model (CRC by polynomial long division, expected sequence
// bit, consecutive bad-frame run). Honours SAW_RX_ERRCNT_EN for link_err.
module tb_saw_receiver;

    localparam int BW       = 40;
    localparam int CRC_BW   = 8;
    localparam int MAX_NACK = 7;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [BW+CRC_BW-1:0] frame_in;
    logic                 frame_valid;
    logic [BW-2:0]        data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 ack;
    logic                 ack_seq;
    logic                 nack;
    logic                 link_err;

    always #5 clk = ~clk;

    saw_receiver #(
        .BW       (BW),
        .CRC_BW   (CRC_BW),
        .MAX_NACK (MAX_NACK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .ack         (ack),
        .ack_seq     (ack_seq),
        .nack        (nack),
        .link_err    (link_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_exp_seq;
    int m_run;
    bit m_link;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Remainder of v(x) mod (x^8 + x^2 + x + 1) by long division.
    function automatic logic [7:0] poly_mod(input logic [47:0] v);
        logic [47:0] t;
        t = v;
        for (int i = 47; i >= 8; i--) begin
            if (t[i]) t = t ^ (48'h107 << (i - 8));
        end
        return t[7:0];
    endfunction

    function automatic logic [47:0] make_frame(input logic seq, input logic [38:0] data);
        logic [39:0] p;
        p = {seq, data};
        return {p, poly_mod({p, 8'h00})};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_exp_seq = 1'b0;
        m_run     = 0;
        m_link    = 1'b0;
    endtask

    task automatic check_link(input string tag);
`ifdef SAW_RX_ERRCNT_EN
        check_eq(tag, link_err, m_link);
`else
        check_eq(tag, link_err, 1'b0);
`endif
    endtask

    // ready_mode: 0 random ready, 1 ready held high, 2 ready low for 10 cycles
    task automatic send(input logic [47:0] f, input int ready_mode);
        bit          good;
        bit          seq;
        logic [38:0] data;
        bit          rdy;
        bit          done;
        good = (poly_mod(f) == 8'h00);
        seq  = f[47];
        data = f[46:8];

        frame_in    = f;
        frame_valid = 1'b1;
        data_ready  = (ready_mode == 1);
        step();
        frame_valid = 1'b0;
        frame_in    = {$urandom, $urandom};
        check_eq("chk_ack_idle",  ack, 1'b0);
        check_eq("chk_nack_idle", nack, 1'b0);
        check_eq("chk_dv_idle",   data_valid, 1'b0);
        step();

        if (!good) begin
            if (m_run < MAX_NACK) m_run++;
            if (m_run == MAX_NACK) m_link = 1'b1;
            check_eq("bad_nack", nack, 1'b1);
            check_eq("bad_ack",  ack, 1'b0);
            check_eq("bad_dv",   data_valid, 1'b0);
            check_link("bad_link_err");
        end else if (seq != m_exp_seq) begin
            m_run = 0;
            check_eq("dup_ack",     ack, 1'b1);
            check_eq("dup_ack_seq", ack_seq, seq);
            check_eq("dup_nack",    nack, 1'b0);
            check_eq("dup_dv",      data_valid, 1'b0);
            check_link("dup_link_err");
        end else begin
            m_run = 0;
            check_eq("new_dv",   data_valid, 1'b1);
            check_eq("new_data", data_out, data);
            check_eq("new_ack",  ack, 1'b0);
            check_eq("new_nack", nack, 1'b0);
            check_link("new_link_err");
            done = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                if (ready_mode == 1)      rdy = 1'b1;
                else if (ready_mode == 2) rdy = (c >= 10);
                else                      rdy = ($urandom_range(3) == 0) || (c >= 12);
                data_ready = rdy;
                // Frames arriving while a payload is pending must be ignored.
                if (c == 3 || $urandom_range(2) == 0) begin
                    frame_valid = 1'b1;
                    frame_in    = make_frame(~m_exp_seq, 39'($urandom));
                end
                step();
                frame_valid = 1'b0;
                if (rdy) begin
                    check_eq("dlv_ack",     ack, 1'b1);
                    check_eq("dlv_ack_seq", ack_seq, seq);
                    check_eq("dlv_dv_clr",  data_valid, 1'b0);
                    check_eq("dlv_nack",    nack, 1'b0);
                    m_exp_seq  = ~m_exp_seq;
                    data_ready = 1'b0;
                    done       = 1'b1;
                end else begin
                    check_eq("hold_dv",   data_valid, 1'b1);
                    check_eq("hold_data", data_out, data);
                    check_eq("hold_ack",  ack, 1'b0);
                end
            end
            if (!done) check_eq("dlv_timeout", 1'b0, 1'b1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [47:0] f0;
        logic [47:0] f;
        int          kind;

        rst         = 1'b1;
        frame_in    = '0;
        frame_valid = 1'b0;
        data_ready  = 1'b0;
        model_reset();
        step();
        step();
        check_eq("rst_data_out", data_out, '0);
        check_eq("rst_dv",       data_valid, 1'b0);
        check_eq("rst_ack",      ack, 1'b0);
        check_eq("rst_ack_seq",  ack_seq, 1'b0);
        check_eq("rst_nack",     nack, 1'b0);
        check_eq("rst_link_err", link_err, 1'b0);
        rst = 1'b0;
        step();

        // Good seq-0 frame, ready held high.
        f0 = make_frame(1'b0, 39'h12_3456_789A);
        send(f0, 1);
        // Same frame with bit 5 flipped.
        send(f0 ^ 48'h20, 1);
        // Same good frame again: duplicate.
        send(f0, 1);
        // Seq-1 frame with ready held low for 10 cycles.
        send(make_frame(1'b1, 39'($urandom)), 2);
        // Seven consecutive bad frames, then a good one.
        for (int k = 0; k < MAX_NACK; k++) begin
            f = make_frame(1'($urandom), 39'($urandom));
            send(f ^ (48'h1 << $urandom_range(47)), 0);
        end
        send(make_frame(1'($urandom), 39'($urandom)), 0);

        // All-zero frame is a good seq-0 frame.
        send('0, 0);

        // Reset while a payload is pending in DELIVER.
        f = make_frame(m_exp_seq, 39'($urandom));
        frame_in    = f;
        frame_valid = 1'b1;
        data_ready  = 1'b0;
        step();
        frame_valid = 1'b0;
        step();
        check_eq("pre_rst_dv", data_valid, 1'b1);
        rst        = 1'b1;
        data_ready = 1'b1;
        step();
        rst        = 1'b0;
        data_ready = 1'b0;
        model_reset();
        check_eq("mid_rst_dv",       data_valid, 1'b0);
        check_eq("mid_rst_data_out", data_out, '0);
        check_eq("mid_rst_ack",      ack, 1'b0);
        check_eq("mid_rst_ack_seq",  ack_seq, 1'b0);
        check_eq("mid_rst_nack",     nack, 1'b0);
        check_eq("mid_rst_link_err", link_err, 1'b0);
        send(make_frame(1'b0, 39'($urandom)), 1);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(9);
            f = make_frame(1'($urandom), 39'({$urandom, $urandom}));
            if (kind < 3) f = f ^ (48'h1 << $urandom_range(47));
            if (kind == 3) f = f ^ (48'h1 << $urandom_range(47)) ^ (48'h1 << $urandom_range(47));
            send(f, (kind == 9) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
